// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, direct-mapped I-cache, refill FSM
module fetch_unit #(
  parameter int          LINE_WORDS = 4,
  parameter int          NUM_LINES  = 16,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    PC_Src,
  input  logic [31:0]             branch_target,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic                    mem_ready,
  input  logic [32*LINE_WORDS-1:0] mem_data_line,
  output logic [31:0]             instruction,
  output logic [31:0]             next_PC,
  output logic                    valid,
  output logic                    hit
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int SEL_W = OFF_W + 5;

  typedef enum logic {
    LOOKUP = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t state, state_next;

  logic [31:0]             pc;
  logic                    pending;
  logic [31:0]             pend_addr;
  logic [NUM_LINES-1:0]    line_valid;
  logic [TAG_W-1:0]        tag_mem  [NUM_LINES];
  logic [32*LINE_WORDS-1:0] data_mem [NUM_LINES];

  logic [IDX_W-1:0] pc_index;
  logic [TAG_W-1:0] pc_tag;
  logic [SEL_W-1:0] word_sel;
  logic [IDX_W-1:0] fill_index;
  logic [TAG_W-1:0] fill_tag;
  logic [31:0]      redirect_addr;
  logic [31:0]      lookup_word;
  logic             lookup_hit;
  logic             fill;

  assign pc_index      = pc[2+OFF_W +: IDX_W];
  assign pc_tag        = pc[31 -: TAG_W];
  assign fill_index    = mem_addr[2+OFF_W +: IDX_W];
  assign fill_tag      = mem_addr[31 -: TAG_W];
  assign redirect_addr = branch_target & ~32'd3;

  // Single-word lines have no offset field, so the word select collapses to zero.
  if (OFF_W == 0) begin : g_one_word
    assign word_sel = '0;
  end else begin : g_multi_word
    assign word_sel = {pc[2 +: OFF_W], 5'b0};
  end

  assign lookup_hit  = line_valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign lookup_word = data_mem[pc_index][word_sel +: 32];
  assign fill        = (state == REFILL) && mem_req && mem_ready;

  always_comb begin
    state_next = state;
    case (state)
      LOOKUP: if (!PC_Src && !stall && !lookup_hit) state_next = REFILL;
      REFILL: if (fill) state_next = LOOKUP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= LOOKUP;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      pending     <= 1'b0;
      pend_addr   <= '0;
      line_valid  <= '0;
      instruction <= '0;
      next_PC     <= '0;
      valid       <= 1'b0;
      hit         <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else begin
      case (state)
        LOOKUP: begin
          if (PC_Src) begin
            pc    <= redirect_addr;
            valid <= 1'b0;
            hit   <= 1'b0;
          end else if (stall) begin
            hit <= 1'b0;
          end else if (lookup_hit) begin
            instruction <= lookup_word;
            next_PC     <= pc + 32'd4;
            valid       <= 1'b1;
            hit         <= 1'b1;
            pc          <= pc + 32'd4;
          end else begin
            valid    <= 1'b0;
            hit      <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= {pc[31:2+OFF_W], {(OFF_W+2){1'b0}}};
          end
        end
        REFILL: begin
          valid <= 1'b0;
          hit   <= 1'b0;
          if (fill) begin
            line_valid[fill_index] <= 1'b1;
            mem_req <= 1'b0;
            pending <= 1'b0;
            // A redirect in the completing cycle beats an older pending one.
            if (PC_Src)       pc <= redirect_addr;
            else if (pending) pc <= pend_addr;
          end else if (PC_Src) begin
            pending   <= 1'b1;
            pend_addr <= redirect_addr;
          end
        end
      endcase
    end
  end

  // Line storage carries no reset; line_valid alone decides whether contents count.
  always_ff @(posedge clock) begin
    if (fill) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= mem_data_line;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: directed scenarios plus randomized model run
module tb_fetch_unit;

  localparam int LW = 4;
  localparam int NL = 16;

  logic            clock = 1'b0;
  logic            reset, stall, PC_Src, mem_ready;
  logic [31:0]     branch_target;
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic [32*LW-1:0] mem_data_line;
  logic [31:0]     instruction, next_PC;
  logic            valid, hit;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fetch_unit #(.LINE_WORDS(LW), .NUM_LINES(NL), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .stall(stall), .PC_Src(PC_Src),
    .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data_line(mem_data_line),
    .instruction(instruction), .next_PC(next_PC), .valid(valid), .hit(hit)
  );

  // Backing memory content: word at byte address a is a/4 + 1.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {2'b00, a[31:2]} + 32'd1;
  endfunction

  function automatic logic [32*LW-1:0] line_at(input logic [31:0] a);
    logic [32*LW-1:0] l;
    logic [31:0] base;
    base = a & ~(32'(4*LW) - 32'd1);
    for (int w = 0; w < LW; w++) l[w*32 +: 32] = word_at(base + 32'(4*w));
    return l;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; PC_Src = 1'b0; branch_target = '0;
    mem_ready = 1'b0; mem_data_line = '0;
    tick(); tick();
    checks++;
    if ({instruction, next_PC, valid, hit, mem_req, mem_addr} !== 99'd0) begin
      failures++;
      $display("FAIL reset_outputs actual instr=%0h npc=%0h v=%0b h=%0b req=%0b addr=%0h expected all 0",
               instruction, next_PC, valid, hit, mem_req, mem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_cold_miss();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({mem_req, mem_addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
        failures++;
        $display("FAIL cold_req cycle=%0d actual req=%0b addr=%0h v=%0b expected req=1 addr=0 v=0",
                 i, mem_req, mem_addr, valid);
      end
    end
    mem_ready = 1'b1; mem_data_line = line_at(32'h0);
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({mem_req, valid} !== 2'b00) begin
      failures++;
      $display("FAIL cold_fill actual req=%0b v=%0b expected 0 0", mem_req, valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({valid, hit, instruction, next_PC} !== {1'b1, 1'b1, 32'(i+1), 32'(4*(i+1))}) begin
        failures++;
        $display("FAIL cold_deliver i=%0d actual v=%0b h=%0b instr=%0h npc=%0h expected 1 1 %0h %0h",
                 i, valid, hit, instruction, next_PC, i+1, 4*(i+1));
      end
    end
  endtask

  task automatic test_line_crossing();
    tick();
    checks++;
    if ({valid, hit, mem_req, mem_addr} !== {1'b0, 1'b0, 1'b1, 32'h10}) begin
      failures++;
      $display("FAIL cross_miss actual v=%0b h=%0b req=%0b addr=%0h expected 0 0 1 10",
               valid, hit, mem_req, mem_addr);
    end
    mem_ready = 1'b1; mem_data_line = line_at(32'h10);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({valid, hit, instruction, next_PC} !== {1'b1, 1'b1, 32'(5+i), 32'(20+4*i)}) begin
        failures++;
        $display("FAIL cross_deliver i=%0d actual v=%0b h=%0b instr=%0h npc=%0h expected 1 1 %0h %0h",
                 i, valid, hit, instruction, next_PC, 5+i, 20+4*i);
      end
    end
  endtask

  task automatic test_redirect_stall();
    PC_Src = 1'b1; stall = 1'b1; branch_target = 32'h7;
    tick();
    PC_Src = 1'b0; stall = 1'b0;
    checks++;
    if ({valid, hit, mem_req} !== 3'b000) begin
      failures++;
      $display("FAIL redir_flush actual v=%0b h=%0b req=%0b expected 0 0 0", valid, hit, mem_req);
    end
    tick();
    checks++;
    if ({valid, hit, instruction, next_PC} !== {1'b1, 1'b1, 32'd2, 32'h8}) begin
      failures++;
      $display("FAIL redir_target actual v=%0b h=%0b instr=%0h npc=%0h expected 1 1 2 8",
               valid, hit, instruction, next_PC);
    end
  endtask

  task automatic test_stall();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({valid, hit, instruction, next_PC} !== {1'b1, 1'b0, 32'd3, 32'hc}) begin
        failures++;
        $display("FAIL stall_hold i=%0d actual v=%0b h=%0b instr=%0h npc=%0h expected 1 0 3 c",
                 i, valid, hit, instruction, next_PC);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({valid, hit, instruction, next_PC} !== {1'b1, 1'b1, 32'(4+i), 32'(16+4*i)}) begin
        failures++;
        $display("FAIL stall_release i=%0d actual instr=%0h npc=%0h v=%0b expected %0h %0h 1",
                 i, instruction, next_PC, valid, 4+i, 16+4*i);
      end
    end
  endtask

  task automatic test_refill_redirect();
    PC_Src = 1'b1; branch_target = 32'h40;
    tick();
    PC_Src = 1'b0;
    tick();
    checks++;
    if ({valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h40}) begin
      failures++;
      $display("FAIL rr_miss actual v=%0b req=%0b addr=%0h expected 0 1 40", valid, mem_req, mem_addr);
    end
    PC_Src = 1'b1; branch_target = 32'h8;
    tick();
    PC_Src = 1'b0;
    tick();
    checks++;
    if ({valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h40}) begin
      failures++;
      $display("FAIL rr_hold actual v=%0b req=%0b addr=%0h expected 0 1 40", valid, mem_req, mem_addr);
    end
    mem_ready = 1'b1; mem_data_line = line_at(32'h40);
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({valid, mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL rr_fill actual v=%0b req=%0b expected 0 0", valid, mem_req);
    end
    tick();
    checks++;
    if ({valid, hit, instruction, next_PC} !== {1'b1, 1'b1, 32'd3, 32'hc}) begin
      failures++;
      $display("FAIL rr_pending actual v=%0b h=%0b instr=%0h npc=%0h expected 1 1 3 c",
               valid, hit, instruction, next_PC);
    end
    PC_Src = 1'b1; branch_target = 32'h40;
    tick();
    PC_Src = 1'b0;
    tick();
    checks++;
    if ({valid, hit, instruction, next_PC, mem_req} !== {1'b1, 1'b1, 32'd17, 32'h44, 1'b0}) begin
      failures++;
      $display("FAIL rr_retained actual v=%0b h=%0b instr=%0h npc=%0h req=%0b expected 1 1 11 44 0",
               valid, hit, instruction, next_PC, mem_req);
    end
  endtask

  task automatic test_alias_reset();
    PC_Src = 1'b1; branch_target = 32'h0;
    tick();
    PC_Src = 1'b0;
    tick();
    checks++;
    if ({valid, instruction} !== {1'b1, 32'd1}) begin
      failures++;
      $display("FAIL alias_first actual v=%0b instr=%0h expected 1 1", valid, instruction);
    end
    PC_Src = 1'b1; branch_target = 32'(4*LW*NL);
    tick();
    PC_Src = 1'b0;
    tick();
    checks++;
    if ({valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'(4*LW*NL)}) begin
      failures++;
      $display("FAIL alias_miss actual v=%0b req=%0b addr=%0h expected 0 1 %0h",
               valid, mem_req, mem_addr, 4*LW*NL);
    end
    mem_ready = 1'b1; mem_data_line = line_at(32'(4*LW*NL));
    tick();
    mem_ready = 1'b0;
    tick();
    checks++;
    if ({valid, instruction} !== {1'b1, word_at(32'(4*LW*NL))}) begin
      failures++;
      $display("FAIL alias_deliver actual v=%0b instr=%0h expected 1 %0h",
               valid, instruction, word_at(32'(4*LW*NL)));
    end
    PC_Src = 1'b1; branch_target = 32'h0;
    tick();
    PC_Src = 1'b0;
    tick();
    checks++;
    if ({valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL alias_evicted actual v=%0b req=%0b addr=%0h expected 0 1 0", valid, mem_req, mem_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({instruction, next_PC, valid, hit, mem_req, mem_addr} !== 99'd0) begin
      failures++;
      $display("FAIL reset_in_refill actual instr=%0h npc=%0h v=%0b h=%0b req=%0b addr=%0h expected all 0",
               instruction, next_PC, valid, hit, mem_req, mem_addr);
    end
    mem_ready = 1'b1; mem_data_line = line_at(32'h0);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h0}) begin
        failures++;
        $display("FAIL reset_stray_ready i=%0d actual v=%0b req=%0b addr=%0h expected 0 1 0",
                 i, valid, mem_req, mem_addr);
      end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    PC_Src = 1'b1; branch_target = 32'(4*LW*NL);
    tick();
    PC_Src = 1'b0;
    tick();
    checks++;
    if ({valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'(4*LW*NL)}) begin
      failures++;
      $display("FAIL reset_cleared_alias actual v=%0b req=%0b addr=%0h expected 0 1 %0h",
               valid, mem_req, mem_addr, 4*LW*NL);
    end
  endtask

  task automatic test_random();
    bit          m_valid [NL];
    logic [31:0] m_line  [NL];
    logic [31:0] exp_pc, line_base, prev_bt, prev_addr;
    logic        prev_stall, prev_src, prev_ready, prev_req, present;
    logic [64:0] held;
    int          lat, idx;
    reset = 1'b1; stall = 1'b0; PC_Src = 1'b0; mem_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    exp_pc = 32'h0;
    lat = -1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      stall  = ($urandom_range(0, 4) == 0);
      PC_Src = ($urandom_range(0, 15) == 0);
      branch_target = ($urandom_range(0, 40) == 0) ? 32'hFFFF_FFF4 : 32'($urandom_range(0, 'h7FF));
      if (mem_req) begin
        if (lat < 0) lat = $urandom_range(0, 3);
        if (lat == 0) begin
          mem_ready = 1'b1; mem_data_line = line_at(mem_addr); lat = -1;
        end else begin
          mem_ready = 1'b0; lat--;
        end
      end else begin
        lat = -1;
        mem_ready = ($urandom_range(0, 19) == 0);
        mem_data_line = {LW{$urandom()}};
      end
      prev_stall = stall; prev_src = PC_Src; prev_bt = branch_target; prev_ready = mem_ready;
      prev_req = mem_req; prev_addr = mem_addr; held = {instruction, next_PC, valid};
      tick();
      if (prev_ready && prev_req) begin
        idx = int'((prev_addr >> (2 + $clog2(LW))) % NL);
        m_valid[idx] = 1'b1;
        m_line[idx] = prev_addr;
      end
      if (prev_src || prev_req) begin
        checks++;
        if ({valid, hit, mem_req} !== {1'b0, 1'b0, prev_req & ~prev_ready} ||
            (mem_req === 1'b1 && mem_addr !== prev_addr)) begin
          failures++;
          $display("FAIL rnd_flush_refill cyc=%0d actual v=%0b h=%0b req=%0b addr=%0h expected 0 0 %0b %0h",
                   cyc, valid, hit, mem_req, mem_addr, prev_req & ~prev_ready, prev_addr);
        end
        if (prev_src) exp_pc = prev_bt & ~32'd3;
      end else if (prev_stall) begin
        checks++;
        if ({instruction, next_PC, valid, hit, mem_req} !== {held, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL rnd_stall cyc=%0d actual instr=%0h npc=%0h v=%0b h=%0b req=%0b expected held %0h",
                   cyc, instruction, next_PC, valid, hit, mem_req, held);
        end
      end else begin
        line_base = exp_pc & ~(32'(4*LW) - 32'd1);
        idx = int'((exp_pc >> (2 + $clog2(LW))) % NL);
        present = m_valid[idx] && (m_line[idx] == line_base);
        checks++;
        if (present) begin
          if ({valid, hit, instruction, next_PC, mem_req} !==
              {1'b1, 1'b1, word_at(exp_pc), exp_pc + 32'd4, 1'b0}) begin
            failures++;
            $display("FAIL rnd_hit cyc=%0d pc=%0h actual v=%0b h=%0b instr=%0h npc=%0h req=%0b expected 1 1 %0h %0h 0",
                     cyc, exp_pc, valid, hit, instruction, next_PC, mem_req, word_at(exp_pc), exp_pc + 32'd4);
          end
          exp_pc = exp_pc + 32'd4;
        end else if ({valid, hit, mem_req, mem_addr} !== {1'b0, 1'b0, 1'b1, line_base}) begin
          failures++;
          $display("FAIL rnd_miss cyc=%0d pc=%0h actual v=%0b h=%0b req=%0b addr=%0h expected 0 0 1 %0h",
                   cyc, exp_pc, valid, hit, mem_req, mem_addr, line_base);
        end
      end
    end
    stall = 1'b0; PC_Src = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_line_crossing();
    test_redirect_stall();
    test_stall();
    test_refill_redirect();
    test_alias_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
